// File: rtl/requant_pkg.sv
// requant_pkg: shared types and constants for the requantisation stage.
// Holds the FSM state enum, lane/width parameters, the rounding nudge and
// the per-lane clamp helper used by requant_stage.
package requant_pkg;

  localparam int LANES = 4;
  localparam int ACC_W = 32;
  localparam int OUT_W = 8;

  // Added before the >>31 so the high-multiply rounds half up.
  localparam logic signed [63:0] ROUND_NUDGE = 64'sd1 <<< 30;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_RND  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  // max(y, mn) followed by min(., mx). Written so only the surviving
  // 8-bit value is returned; when mn > mx the result collapses to mx.
  function automatic logic [OUT_W-1:0] clamp_lane(
    input logic signed [33:0]      y,
    input logic signed [OUT_W-1:0] mn,
    input logic signed [OUT_W-1:0] mx
  );
    logic [OUT_W-1:0] res;
    if (y < mn) begin
      res = (mn > mx) ? mx : mn;
    end else if (y > mx) begin
      res = mx;
    end else begin
      res = y[OUT_W-1:0];
    end
    return res;
  endfunction

endpackage

// File: rtl/requant_stage_srdhm.sv
// srdhm: saturating rounding doubling high multiply, purely combinational.
// Ports: a_i, b_i  signed 32-bit operands (accumulator, Q31 multiplier)
//        h_o       signed 32-bit floor((a*b + 2^30) / 2^31), saturated
module srdhm
  import requant_pkg::*;
(
  input  logic signed [ACC_W-1:0] a_i,
  input  logic signed [ACC_W-1:0] b_i,
  output logic signed [ACC_W-1:0] h_o
);

  logic signed [63:0] prod;
  logic signed [63:0] sum;
  logic               sat;
  logic               unused_sum_bits;

  // The one 32x32 signed multiplier in the stage.
  assign prod = a_i * b_i;

  // |prod| <= 2^62, so adding 2^30 cannot overflow 64 bits.
  assign sum = prod + ROUND_NUDGE;

  // Only -2^31 * -2^31 produces a quotient of 2^31, which does not fit.
  assign sat = (a_i == 32'sh8000_0000) && (b_i == 32'sh8000_0000);

  // An arithmetic >>31 is a floor division; bits [62:31] hold the result.
  assign h_o = sat ? 32'sh7FFF_FFFF : sum[62:31];

  assign unused_sum_bits = ^{sum[63], sum[30:0]};

endmodule

// File: rtl/requant_stage.sv
// requant_stage: requantises four int32 accumulators to packed int8 lanes.
// Ports: clk/reset (sync, active-high); in_valid/in_ready + acc0..3, mult,
//        shift, zero_pt, act_min, act_max in; out_valid/out_ready + out_data out.
module requant_stage
  import requant_pkg::*;
(
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [ACC_W-1:0]        acc0,
  input  logic [ACC_W-1:0]        acc1,
  input  logic [ACC_W-1:0]        acc2,
  input  logic [ACC_W-1:0]        acc3,
  input  logic [ACC_W-1:0]        mult,
  input  logic [4:0]              shift,
  input  logic [OUT_W-1:0]        zero_pt,
  input  logic [OUT_W-1:0]        act_min,
  input  logic [OUT_W-1:0]        act_max,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [LANES*OUT_W-1:0]  out_data
);

  state_e                  state_q;
  logic [1:0]              lane_q;
  logic                    in_ready_q;
  logic                    out_valid_q;
  logic [LANES*OUT_W-1:0]  out_data_q;

  // Operand set captured at acceptance; inputs are ignored afterwards.
  logic signed [ACC_W-1:0] acc_q [LANES];
  logic signed [ACC_W-1:0] mult_q;
  logic [4:0]              shift_q;
  logic signed [OUT_W-1:0] zp_q;
  logic signed [OUT_W-1:0] min_q;
  logic signed [OUT_W-1:0] max_q;

  // High-multiply result of the current lane, registered in MUL.
  logic signed [ACC_W-1:0] h_q;

  logic signed [ACC_W-1:0] mul_a;
  logic signed [ACC_W-1:0] h_d;
  logic signed [32:0]      h_ext;
  logic signed [32:0]      nudge;
  logic signed [32:0]      r;
  logic signed [33:0]      y;
  logic [OUT_W-1:0]        byte_d;

  // Lane mux feeding the shared multiplier.
  assign mul_a = acc_q[lane_q];

  srdhm u_srdhm (
    .a_i (mul_a),
    .b_i (mult_q),
    .h_o (h_d)
  );

  // Rounding right shift: 33 bits so h + 2^30 never wraps.
  assign h_ext = {h_q[ACC_W-1], h_q};

  always_comb begin
    nudge = '0;
    if (shift_q != 5'd0) begin
      nudge = 33'sd1 <<< (shift_q - 5'd1);
    end
  end

  assign r = (h_ext + nudge) >>> shift_q;

  // Zero-point add widened by one more bit, then clamped to the bounds.
  assign y      = {r[32], r} + {{26{zp_q[OUT_W-1]}}, zp_q};
  assign byte_d = clamp_lane(y, min_q, max_q);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      lane_q      <= 2'd0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      h_q         <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (in_valid) begin
            acc_q[0]   <= acc0;
            acc_q[1]   <= acc1;
            acc_q[2]   <= acc2;
            acc_q[3]   <= acc3;
            mult_q     <= mult;
            shift_q    <= shift;
            zp_q       <= zero_pt;
            min_q      <= act_min;
            max_q      <= act_max;
            lane_q     <= 2'd0;
            in_ready_q <= 1'b0;
            state_q    <= ST_MUL;
          end
        end
        ST_MUL: begin
          h_q     <= h_d;
          state_q <= ST_RND;
        end
        ST_RND: begin
          out_data_q[{lane_q, 3'b000} +: OUT_W] <= byte_d;
          if (lane_q == 2'd3) begin
            out_valid_q <= 1'b1;
            state_q     <= ST_DONE;
          end else begin
            lane_q  <= lane_q + 2'd1;
            state_q <= ST_MUL;
          end
        end
        ST_DONE: begin
          // Result held until the consumer takes it.
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= ST_IDLE;
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;

endmodule
